// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and constants for the segment scan controller
package seg_scan_pkg;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_t;

  // Index 0 is the rightmost entry; segment order {g,f,e,d,c,b,a}.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// rtl/hex7seg_dec.sv - combinational hex nibble to 7-segment pattern decoder
module hex7seg_dec
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_LUT[i_nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - double-buffered, blinkable, time-multiplexed 7-segment scan controller
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int PRESCALE  = 50000,
  parameter int GUARD     = 500,
  parameter int BLINK_DIV = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [$clog2(DIGITS)-1:0] wr_idx,
  input  logic [3:0]                wr_nibble,
  input  logic                      wr_blink,
  output logic [DIGITS-1:0]         an,
  output logic [6:0]                seg,
  output logic                      frame_tick
);

  localparam int KW = $clog2(DIGITS);
  localparam int CW = $clog2(max_int(PRESCALE, GUARD));
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GUARD - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_DIV - 1);

  // Scan position registers hold the slot position that the next edge will display.
  scan_state_t       r_state;
  logic [KW-1:0]     r_k;
  logic [CW-1:0]     r_cnt;

  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;
  logic              r_frame_tick;
  logic              r_wr_ready;

  logic [3:0]        r_shadow_nib [DIGITS];
  logic [3:0]        r_active_nib [DIGITS];
  logic [DIGITS-1:0] r_shadow_blink;
  logic [DIGITS-1:0] r_active_blink;
  logic              r_blink_phase;
  logic [FW-1:0]     r_frame_cnt;

  logic [3:0]        w_nib;
  logic              w_blink;
  logic              w_phase;
  logic              w_tick_next;
  logic [DIGITS-1:0] w_onehot;
  logic [6:0]        w_seg;

  // The commit edge also renders the first slot of the new frame, so bypass to the shadow set there.
  always_comb begin
    w_nib       = r_frame_tick ? r_shadow_nib[r_k]   : r_active_nib[r_k];
    w_blink     = r_frame_tick ? r_shadow_blink[r_k] : r_active_blink[r_k];
    w_phase     = (r_frame_tick && (r_frame_cnt == FRM_LAST)) ? ~r_blink_phase : r_blink_phase;
    w_tick_next = (r_state == GAP) && (r_k == K_LAST) && (r_cnt == GAP_LAST);
    w_onehot    = DIGITS'(1) << r_k;
  end

  hex7seg_dec u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  // Scan FSM: advances slot position and registers the display outputs for the cycle being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= SHOW;
      r_k          <= '0;
      r_cnt        <= '0;
      r_an         <= '0;
      r_seg        <= SEG_BLANK;
      r_frame_tick <= 1'b0;
      r_wr_ready   <= 1'b0;
    end else begin
      r_frame_tick <= w_tick_next;
      r_wr_ready   <= ~w_tick_next;
      case (r_state)
        SHOW: begin
          r_an  <= (w_phase && w_blink) ? '0 : w_onehot;
          r_seg <= w_seg;
          if (r_cnt == SHOW_LAST) begin
            r_state <= GAP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAP: begin
          r_an <= '0;
          if (r_cnt == GAP_LAST) begin
            r_state <= SHOW;
            r_cnt   <= '0;
            r_k     <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= SHOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Shadow writes, frame commit to the active set, and blink half-period counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow_nib   <= '{default: 4'h0};
      r_active_nib   <= '{default: 4'h0};
      r_shadow_blink <= '0;
      r_active_blink <= '0;
      r_blink_phase  <= 1'b0;
      r_frame_cnt    <= '0;
    end else begin
      if (wr_valid && r_wr_ready && (int'(wr_idx) < DIGITS)) begin
        r_shadow_nib[wr_idx]   <= wr_nibble;
        r_shadow_blink[wr_idx] <= wr_blink;
      end
      if (r_frame_tick) begin
        r_active_nib   <= r_shadow_nib;
        r_active_blink <= r_shadow_blink;
        r_blink_phase  <= w_phase;
        r_frame_cnt    <= (r_frame_cnt == FRM_LAST) ? '0 : r_frame_cnt + 1'b1;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_tick = r_frame_tick;
  assign wr_ready   = r_wr_ready;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench with a frame-arithmetic reference model
module tb_seg_scan_ctrl;

  localparam int D     = 4;
  localparam int P     = 4;
  localparam int G     = 1;
  localparam int BD    = 2;
  localparam int SLOT  = P + G;
  localparam int FRAME = D * SLOT;

  logic         clk;
  logic         rst_n;
  logic         wr_valid;
  logic         wr_ready;
  logic [1:0]   wr_idx;
  logic [3:0]   wr_nibble;
  logic         wr_blink;
  logic [D-1:0] an;
  logic [6:0]   seg;
  logic         frame_tick;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Model state: t is the cycle number since reset release (0 = reset cycle, -1 = unknown).
  int t = -1;
  int sh_nib [D];
  int sh_blk [D];
  int ac_nib [D];
  int ac_blk [D];

  seg_scan_ctrl #(
    .DIGITS    (D),
    .PRESCALE  (P),
    .GUARD     (G),
    .BLINK_DIV (BD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_nibble  (wr_nibble),
    .wr_blink   (wr_blink),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;   3: return 7'h4F;
      4: return 7'h66;   5: return 7'h6D;   6: return 7'h7D;   7: return 7'h07;
      8: return 7'h7F;   9: return 7'h6F;   10: return 7'h77;  11: return 7'h7C;
      12: return 7'h39;  13: return 7'h5E;  14: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic bit is_tick(input int tc);
    return (tc >= 1) && (((tc - 1) % FRAME) == FRAME - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Reference model: accepts writes, commits at the end of each frame, tracks cycle number.
  always @(posedge clk) begin
    if (!rst_n) begin
      t = 0;
      for (int i = 0; i < D; i++) begin
        sh_nib[i] = 0; sh_blk[i] = 0; ac_nib[i] = 0; ac_blk[i] = 0;
      end
    end else if (t >= 0) begin
      if (wr_valid && t >= 1 && !is_tick(t)) begin
        sh_nib[wr_idx] = int'(wr_nibble);
        sh_blk[wr_idx] = int'(wr_blink);
      end
      if (is_tick(t)) begin
        for (int i = 0; i < D; i++) begin
          ac_nib[i] = sh_nib[i];
          ac_blk[i] = sh_blk[i];
        end
      end
      t++;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (t == 0) begin
      check($sformatf("an@rst"), 32'(an), 32'd0);
      check($sformatf("seg@rst"), 32'(seg), 32'd0);
      check($sformatf("tick@rst"), 32'(frame_tick), 32'd0);
      check($sformatf("ready@rst"), 32'(wr_ready), 32'd0);
    end else if (t > 0) begin
      int w, d, s, ph;
      logic [D-1:0] e_an;
      w  = (t - 1) % FRAME;
      d  = w / SLOT;
      s  = w % SLOT;
      ph = (((t - 1) / FRAME) / BD) % 2;
      e_an = ((s < P) && !(ph == 1 && ac_blk[d] == 1)) ? D'(1 << d) : '0;
      check($sformatf("an@t%0d", t), 32'(an), 32'(e_an));
      check($sformatf("seg@t%0d", t), 32'(seg), 32'(seg_of(ac_nib[d])));
      check($sformatf("tick@t%0d", t), 32'(frame_tick), 32'(is_tick(t)));
      check($sformatf("ready@t%0d", t), 32'(wr_ready), 32'(!is_tick(t)));
    end
  end

  task automatic put(input int idx, input int nib, input int blk);
    wr_valid  = 1'b1;
    wr_idx    = 2'(idx);
    wr_nibble = 4'(nib);
    wr_blink  = blk[0];
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_nibble = '0; wr_blink = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("lit_rst_an", 32'(an), 32'h0);
    check("lit_rst_seg", 32'(seg), 32'h00);
    check("lit_rst_ready", 32'(wr_ready), 32'h0);
    rst_n = 1'b1;
    cyc = 0;

    step(1);
    check("lit_c1_an", 32'(an), 32'h1);
    check("lit_c1_seg", 32'(seg), 32'h3F);
    check("lit_c1_ready", 32'(wr_ready), 32'h1);
    step(3);  check("lit_c4_an", 32'(an), 32'h1);
    step(1);  check("lit_c5_an", 32'(an), 32'h0);
    check("lit_c5_seg", 32'(seg), 32'h3F);
    step(1);  check("lit_c6_an", 32'(an), 32'h2);
    step(13); check("lit_c19_tick", 32'(frame_tick), 32'h0);
    step(1);  check("lit_c20_tick", 32'(frame_tick), 32'h1);
    check("lit_c20_ready", 32'(wr_ready), 32'h0);

    step(2);  put(2, 10, 0);
    step(1);  wr_valid = 1'b0;
    step(8);  check("lit_c31_seg", 32'(seg), 32'h3F);
    check("lit_c31_an", 32'(an), 32'h4);
    step(20); check("lit_c51_seg", 32'(seg), 32'h77);

    step(9);  check("lit_c60_ready", 32'(wr_ready), 32'h0);
    put(1, 5, 0);
    step(1);  check("lit_c61_ready", 32'(wr_ready), 32'h1);
    step(1);  wr_valid = 1'b0;
    step(4);  check("lit_c66_seg", 32'(seg), 32'h3F);
    step(20); check("lit_c86_seg", 32'(seg), 32'h6D);

    step(1);  put(3, 7, 0);
    step(1);  put(3, 14, 0);
    step(1);  wr_valid = 1'b0;
    step(27); check("lit_c116_seg", 32'(seg), 32'h79);
    check("lit_c116_an", 32'(an), 32'h8);

    step(1);  put(1, 5, 1);
    step(1);  wr_valid = 1'b0;
    step(8);  check("lit_c126_an", 32'(an), 32'h0);
    check("lit_c126_seg", 32'(seg), 32'h6D);
    step(5);  check("lit_c131_an", 32'(an), 32'h4);
    step(15); check("lit_c146_an", 32'(an), 32'h0);
    step(20); check("lit_c166_an", 32'(an), 32'h2);

    for (int i = 0; i < 400; i++) begin
      step(1);
      wr_valid  = ($urandom_range(0, 2) == 0);
      wr_idx    = 2'($urandom_range(0, 3));
      wr_nibble = 4'($urandom_range(0, 15));
      wr_blink  = ($urandom_range(0, 3) == 0);
    end
    step(1);  put(0, 9, 0);
    step(1);  wr_valid = 1'b0;

    for (int i = 0; i < FRAME && ((cyc - 1) % FRAME) != 2 * SLOT + 1; i++) step(1);
    check("lit_pos_before_reset", 32'((cyc - 1) % FRAME), 32'(2 * SLOT + 1));
    rst_n = 1'b0;
    step(1);  check("lit_midrst_an", 32'(an), 32'h0);
    check("lit_midrst_seg", 32'(seg), 32'h00);
    step(1);  rst_n = 1'b1;
    cyc = 0;
    step(1);  check("lit_post_c1_seg", 32'(seg), 32'h3F);
    step(15); check("lit_post_c16_an", 32'(an), 32'h8);
    check("lit_post_c16_seg", 32'(seg), 32'h3F);
    step(2 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's common-segment 7-segment display bank. It holds one hex nibble per digit in a double-buffered register file and cycles a one-hot digit enable so only one digit is lit at a time. Each lit slot is followed by a guard gap to prevent ghosting, and digits can be blinked individually. It sits between the lab logic that produces digit values and the display pins, replacing the static two-digit enable/select drive.

## Interface
- DIGITS, 4: number of multiplexed digits (2..8).
- PRESCALE, 50000: clock cycles each digit is lit per slot (≥2).
- GUARD, 500: clock cycles with all enables off after each slot (≥1).
- BLINK_DIV, 64: frames per blink half-period (≥1).

- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready on a rising clk edge.
- wr_idx  in  $clog2(DIGITS)  target digit; values ≥ DIGITS are accepted and discarded.
- wr_nibble  in  4  hex value for the digit.
- wr_blink  in  1  blink enable for the digit.
- an  out  DIGITS  one-hot digit enable, active-high, registered.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- Two states: SHOW and GAP. Scan index k ranges over 0..DIGITS-1. Slot counter cnt has width $clog2(max(PRESCALE,GUARD)).
- SHOW:
  - an = onehot(k) unless masked, seg = decode(active_nib[k]).
  - After PRESCALE cycles, go to GAP with cnt=0.
- GAP:
  - an = 0, seg holds its last value.
  - After GUARD cycles, k = (k+1) mod DIGITS, then go to SHOW.
- Frame: DIGITS × (PRESCALE+GUARD) cycles. frame_tick is high on the final GAP cycle of k = DIGITS-1.
- Double buffer:
  - Accepted writes update shadow_nib/shadow_blink[wr_idx].
  - On the frame_tick edge, the full shadow set is copied to active.
  - The lit value therefore never changes mid-frame.
  - Multiple writes to one index within a frame: the last write wins.
- wr_ready is 0 during reset and during the frame_tick cycle; it is 1 otherwise. A write held across the commit cycle is accepted on the next cycle and shows one frame later.
- Blink:
  - blink_phase toggles every BLINK_DIV frames, counted at frame_tick.
  - While blink_phase = 1 and active_blink[k] = 1, an stays 0 for that SHOW slot.
  - Timing is unchanged; the slot is simply dark.
- Decode table, value→seg (hex): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, B→7C, C→39, D→5E, E→79, F→71.

## Timing
- Reset (rst_n low at an edge) sets:
  - an = 0, seg = 7'h00, frame_tick = 0, wr_ready = 0.
  - state = SHOW, k = 0, cnt = 0.
  - All shadow and active nibbles = 0, all blink bits = 0, blink_phase = 0, frame counter = 0.
- First edge with rst_n high: an = onehot(0), seg = 7'h3F, wr_ready = 1. The digit-0 slot spans cycles 1..PRESCALE.
- Outputs are registered. an/seg reflect the state after the edge, with no combinational path from inputs to outputs.
- Write-to-display latency: a value is visible starting with the SHOW slot of its digit in the frame after the next frame_tick. Worst case is just under two frames.
- Reset asserted mid-slot or mid-GAP aborts immediately. The next cycle shows reset values, and pending shadow data is lost.
- A write and frame_tick in the same cycle cannot coincide, because wr_ready is 0.

## Structure
- Package seg_scan_pkg:
  - state enum {SHOW, GAP}.
  - 16-entry SEG_LUT constant (table above).
  - SEG_BLANK = 7'h00.
- Sub-module hex7seg_dec: combinational 4-bit → 7-bit decode using SEG_LUT, instantiated once on active_nib[k].
- Top level contains the FSM, slot and frame counters, shadow/active register arrays, blink logic, and the output registers.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4, GUARD=1, BLINK_DIV=2.
- Reset: hold rst_n low for 3 cycles → an = 0, seg = 00, wr_ready = 0. After release, an = 0001 for 4 cycles, then 0000 for 1 cycle, then 0010. frame_tick first fires at cycle 20.
- Write idx=2, nibble=A mid-frame → digit 2 still shows 3F this frame. After frame_tick, the digit-2 slot shows seg = 77.
- wr_valid held with idx=1, nibble=5 across the frame_tick cycle → wr_ready = 0 on that cycle, the write is accepted on the next cycle, and 6D is shown on digit 1 one frame later.
- Two writes in one frame to idx=3 (7 then E) → digit 3 shows 79 after commit.
- Blink on idx=1 → an[1] stays 0 in frames 3–4, 7–8, …, and lights in frames 1–2 and 5–6. Other digits are unaffected, and slot timing is identical.
- Reset asserted at cycle 2 of digit 2's slot with shadows loaded → the next cycle shows an = 0 and seg = 00. After release, all digits show 3F.
